m2_ctrl: RTL and testbench

Pointer/occupancy controller that drives the address and write-enable side of the `m2` forwarding buffer bank. It turns each of the Tn independent `m2` units into a NUM_WORDS-deep FIFO with valid/ready handshakes on both the producer and consumer sides. It generates `i_wr_addr`, `i_rd_addr` and `i_wen` for `m2`; data flows directly between producer, `m2` and consumer and never passes through this block.

---
 rtl/m2_ctrl_pkg.sv | 13 +
 rtl/m2_ctrl_unit.sv | 69 ++++++
 rtl/m2_ctrl.sv | 44 ++++
 tb/tb_m2_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m2_ctrl_pkg.sv
// rtl/m2_ctrl_pkg.sv - shared defaults and width helpers for the m2 pointer controller
package m2_ctrl_pkg;

    localparam int DEF_TN        = 16;
    localparam int DEF_ADDR      = 2;
    localparam int DEF_NUM_WORDS = 4;

    // Occupancy must be able to represent NUM_WORDS itself, so one bit wider than a pointer.
    function automatic int cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/m2_ctrl_unit.sv
// rtl/m2_ctrl_unit.sv - one lane: write/read pointers, occupancy and handshake flags
module m2_ctrl_unit
    import m2_ctrl_pkg::*;
#(
    parameter int ADDR      = DEF_ADDR,
    parameter int NUM_WORDS = DEF_NUM_WORDS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_flush,
    input  logic                    i_push_valid,
    output logic                    o_push_ready,
    output logic                    o_pop_valid,
    input  logic                    i_pop_ready,
    output logic [ADDR-1:0]         o_wr_addr,
    output logic [ADDR-1:0]         o_rd_addr,
    output logic                    o_wen,
    output logic [cnt_w(ADDR)-1:0]  o_count
);

    localparam int              CW   = cnt_w(ADDR);
    localparam logic [ADDR-1:0] LAST = ADDR'(NUM_WORDS - 1);
    localparam logic [CW-1:0]   FULL = CW'(NUM_WORDS);

    logic [ADDR-1:0] r_wr_ptr;
    logic [ADDR-1:0] r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [ADDR-1:0] w_wr_nxt;
    logic [ADDR-1:0] w_rd_nxt;
    logic            w_push_fire;
    logic            w_pop_fire;

    // Flags from registered occupancy; pointers wrap explicitly so odd depths work.
    // The read address looks ahead so m2 presents the next head right after a pop.
    always_comb begin
        o_push_ready = (r_count != FULL);
        o_pop_valid  = (r_count != '0);
        w_push_fire  = i_push_valid & o_push_ready;
        w_pop_fire   = i_pop_ready & o_pop_valid;
        w_wr_nxt     = (r_wr_ptr == LAST) ? '0 : r_wr_ptr + ADDR'(1);
        w_rd_nxt     = (r_rd_ptr == LAST) ? '0 : r_rd_ptr + ADDR'(1);
        o_wen        = w_push_fire & ~i_flush & ~rst;
        o_wr_addr    = r_wr_ptr;
        o_rd_addr    = i_flush ? '0 : (w_pop_fire ? w_rd_nxt : r_rd_ptr);
        o_count      = r_count;
    end

    // Pointer and occupancy state; flush wins over any handshake in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_fire) r_wr_ptr <= w_wr_nxt;
            if (w_pop_fire)  r_rd_ptr <= w_rd_nxt;
            case ({w_push_fire, w_pop_fire})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/m2_ctrl.sv
// rtl/m2_ctrl.sv - Tn independent FIFO lanes driving the m2 buffer bank address/enable side
module m2_ctrl
    import m2_ctrl_pkg::*;
#(
    parameter int Tn        = DEF_TN,
    parameter int ADDR      = DEF_ADDR,
    parameter int NUM_WORDS = DEF_NUM_WORDS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic [Tn-1:0]            i_push_valid,
    output logic [Tn-1:0]            o_push_ready,
    output logic [Tn-1:0]            o_pop_valid,
    input  logic [Tn-1:0]            i_pop_ready,
    output logic [ADDR*Tn-1:0]       o_wr_addr,
    output logic [ADDR*Tn-1:0]       o_rd_addr,
    output logic [Tn-1:0]            o_wen,
    output logic [cnt_w(ADDR)*Tn-1:0] o_count
);

    localparam int CW = cnt_w(ADDR);

    // One controller per m2 unit; lanes share nothing but clock, reset and flush.
    for (genvar gi = 0; gi < Tn; gi++) begin : g_lane
        m2_ctrl_unit #(
            .ADDR      (ADDR),
            .NUM_WORDS (NUM_WORDS)
        ) u_unit (
            .clk          (clk),
            .rst          (rst),
            .i_flush      (i_flush),
            .i_push_valid (i_push_valid[gi]),
            .o_push_ready (o_push_ready[gi]),
            .o_pop_valid  (o_pop_valid[gi]),
            .i_pop_ready  (i_pop_ready[gi]),
            .o_wr_addr    (o_wr_addr[gi*ADDR +: ADDR]),
            .o_rd_addr    (o_rd_addr[gi*ADDR +: ADDR]),
            .o_wen        (o_wen[gi]),
            .o_count      (o_count[gi*CW +: CW])
        );
    end

endmodule

// File: tb/tb_m2_ctrl.sv
// tb/tb_m2_ctrl.sv - randomized scoreboard bench for m2_ctrl with a behavioural m2 bank
module tb_m2_ctrl;

    localparam int TN = 16;
    localparam int AW = 2;
    localparam int NW = 4;
    localparam int CW = AW + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [TN-1:0]   push_valid, pop_ready, push_ready, pop_valid, wen;
    logic [AW*TN-1:0] wr_addr, rd_addr;
    logic [CW*TN-1:0] count;
    logic [7:0]      pdata [TN];

    // second build: depth 3 inside a 2-bit address space
    logic            b_flush;
    logic [1:0]      b_push_valid, b_pop_ready, b_push_ready, b_pop_valid, b_wen;
    logic [3:0]      b_wr_addr, b_rd_addr;
    logic [5:0]      b_count;

    int n_pass = 0;
    int n_total = 0;

    // reference model: one queue per lane plus wrap-around slot indices
    logic [7:0] q [TN][$];
    int wp [TN];
    int rp [TN];
    bit e_ready [TN], e_valid [TN], e_wen [TN], e_push [TN], e_pop [TN];
    int e_wr [TN], e_rd [TN], e_cnt [TN];

    // behavioural m2 bank: write port, registered read address
    logic [7:0] m2_mem [TN][4];
    logic [1:0] m2_ra [TN];

    always #5 clk = ~clk;

    m2_ctrl #(.Tn(TN), .ADDR(AW), .NUM_WORDS(NW)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (flush),
        .i_push_valid (push_valid),
        .o_push_ready (push_ready),
        .o_pop_valid  (pop_valid),
        .i_pop_ready  (pop_ready),
        .o_wr_addr    (wr_addr),
        .o_rd_addr    (rd_addr),
        .o_wen        (wen),
        .o_count      (count)
    );

    m2_ctrl #(.Tn(2), .ADDR(2), .NUM_WORDS(3)) u_dut3 (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (b_flush),
        .i_push_valid (b_push_valid),
        .o_push_ready (b_push_ready),
        .o_pop_valid  (b_pop_valid),
        .i_pop_ready  (b_pop_ready),
        .o_wr_addr    (b_wr_addr),
        .o_rd_addr    (b_rd_addr),
        .o_wen        (b_wen),
        .o_count      (b_count)
    );

    always @(posedge clk) begin
        for (int l = 0; l < TN; l++) begin
            if (wen[l]) m2_mem[l][wr_addr[l*AW +: AW]] <= pdata[l];
            m2_ra[l] <= rd_addr[l*AW +: AW];
        end
    end

    function automatic logic [7:0] head(input int l);
        return m2_mem[l][m2_ra[l]];
    endfunction

    task automatic model_clear();
        for (int l = 0; l < TN; l++) begin
            q[l].delete();
            wp[l] = 0;
            rp[l] = 0;
        end
    endtask

    task automatic predict();
        for (int l = 0; l < TN; l++) begin
            int n;
            n = q[l].size();
            e_cnt[l]   = n;
            e_ready[l] = (n != NW);
            e_valid[l] = (n != 0);
            e_push[l]  = push_valid[l] && e_ready[l];
            e_pop[l]   = pop_ready[l] && e_valid[l];
            e_wen[l]   = e_push[l] && !flush;
            e_wr[l]    = wp[l];
            e_rd[l]    = flush ? 0 : (e_pop[l] ? (rp[l] + 1) % NW : rp[l]);
        end
    endtask

    task automatic commit();
        for (int l = 0; l < TN; l++) begin
            if (flush) begin
                q[l].delete();
                wp[l] = 0;
                rp[l] = 0;
            end else begin
                if (e_push[l]) begin
                    q[l].push_back(pdata[l]);
                    wp[l] = (wp[l] + 1) % NW;
                end
                if (e_pop[l]) begin
                    void'(q[l].pop_front());
                    rp[l] = (rp[l] + 1) % NW;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush = 1'b0;
        push_valid = '0;
        pop_ready = '0;
        b_flush = 1'b0;
        b_push_valid = '0;
        b_pop_ready = '0;
        for (int l = 0; l < TN; l++) pdata[l] = 8'h00;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        #1;
        n_total++; if (push_ready !== 16'hFFFF) $display("FAIL reset_push_ready got %h want ffff", push_ready); else n_pass++;
        n_total++; if (pop_valid !== 16'h0000) $display("FAIL reset_pop_valid got %h want 0", pop_valid); else n_pass++;
        n_total++; if (wen !== 16'h0000) $display("FAIL reset_wen got %h want 0", wen); else n_pass++;
        n_total++; if (count !== '0) $display("FAIL reset_count got %h want 0", count); else n_pass++;
        n_total++; if (wr_addr !== '0) $display("FAIL reset_wr_addr got %h want 0", wr_addr); else n_pass++;
        n_total++; if (rd_addr !== '0) $display("FAIL reset_rd_addr got %h want 0", rd_addr); else n_pass++;
    endtask

    task automatic test_fill_lane3();
        for (int k = 0; k < 5; k++) begin
            push_valid = 16'h0008;
            pdata[3] = 8'hA1 + 8'(k);
            #1;
            predict();
            n_total++; if (wr_addr[7:6] !== 2'(k % NW)) $display("FAIL fill_wr_addr k=%0d got %0d want %0d", k, wr_addr[7:6], k % NW); else n_pass++;
            n_total++; if (wen[3] !== (k < 4)) $display("FAIL fill_wen k=%0d got %b want %b", k, wen[3], k < 4); else n_pass++;
            n_total++; if (push_ready[3] !== e_ready[3]) $display("FAIL fill_push_ready k=%0d got %b want %b", k, push_ready[3], e_ready[3]); else n_pass++;
            commit();
        end
        push_valid = '0;
        #1;
        n_total++; if (count[11:9] !== 3'd4) $display("FAIL fill_count got %0d want 4", count[11:9]); else n_pass++;
        n_total++; if (push_ready[3] !== 1'b0) $display("FAIL fill_full_ready got %b want 0", push_ready[3]); else n_pass++;
    endtask

    task automatic test_drain_lane3();
        for (int k = 0; k < 5; k++) begin
            pop_ready = 16'h0008;
            #1;
            predict();
            n_total++; if (pop_valid[3] !== (k < 4)) $display("FAIL drain_valid k=%0d got %b want %b", k, pop_valid[3], k < 4); else n_pass++;
            if (k < 4) begin
                n_total++; if (head(3) !== 8'hA1 + 8'(k)) $display("FAIL drain_data k=%0d got %h want %h", k, head(3), 8'hA1 + 8'(k)); else n_pass++;
            end
            n_total++; if (rd_addr[7:6] !== 2'(e_rd[3])) $display("FAIL drain_rd_addr k=%0d got %0d want %0d", k, rd_addr[7:6], e_rd[3]); else n_pass++;
            commit();
        end
        pop_ready = '0;
        #1;
        n_total++; if (rd_addr[7:6] !== 2'd0) $display("FAIL drain_rd_wrap got %0d want 0", rd_addr[7:6]); else n_pass++;
    endtask

    task automatic test_stream_lane0();
        for (int k = 0; k < 2; k++) begin
            push_valid = 16'h0001;
            pdata[0] = 8'($urandom);
            #1; predict(); commit();
        end
        for (int k = 0; k < 10; k++) begin
            push_valid = 16'h0001;
            pop_ready = 16'h0001;
            pdata[0] = 8'($urandom);
            #1;
            predict();
            n_total++; if (count[2:0] !== 3'd2) $display("FAIL stream_count k=%0d got %0d want 2", k, count[2:0]); else n_pass++;
            n_total++; if (pop_valid[0] !== 1'b1 || push_ready[0] !== 1'b1) $display("FAIL stream_flags k=%0d got %b%b want 11", k, pop_valid[0], push_ready[0]); else n_pass++;
            n_total++; if (head(0) !== q[0][0]) $display("FAIL stream_data k=%0d got %h want %h", k, head(0), q[0][0]); else n_pass++;
            n_total++; if (wr_addr[1:0] !== 2'(e_wr[0]) || rd_addr[1:0] !== 2'(e_rd[0])) $display("FAIL stream_addr k=%0d got %0d/%0d want %0d/%0d", k, wr_addr[1:0], rd_addr[1:0], e_wr[0], e_rd[0]); else n_pass++;
            commit();
        end
        push_valid = '0;
        pop_ready = 16'h0001;
        for (int k = 0; k < 2; k++) begin
            #1; predict(); commit();
        end
        pop_ready = '0;
    endtask

    task automatic test_nw3();
        for (int c = 0; c < 6; c++) begin
            b_push_valid = (c < 5) ? 2'b01 : 2'b00;
            b_pop_ready  = (c > 0) ? 2'b01 : 2'b00;
            #1;
            if (c < 5) begin
                n_total++; if (b_wr_addr[1:0] !== 2'(c % 3) || b_wen[0] !== 1'b1) $display("FAIL nw3_wr c=%0d got %0d wen %b want %0d", c, b_wr_addr[1:0], b_wen[0], c % 3); else n_pass++;
            end
            if (c > 0) begin
                n_total++; if (b_rd_addr[1:0] !== 2'(c % 3)) $display("FAIL nw3_rd c=%0d got %0d want %0d", c, b_rd_addr[1:0], c % 3); else n_pass++;
                n_total++; if (b_count[2:0] !== 3'd1) $display("FAIL nw3_count c=%0d got %0d want 1", c, b_count[2:0]); else n_pass++;
            end
            @(posedge clk); @(negedge clk);
        end
        b_push_valid = '0;
        b_pop_ready = '0;
        #1;
        n_total++; if (b_count[2:0] !== 3'd0 || b_pop_valid[0] !== 1'b0) $display("FAIL nw3_empty got cnt %0d valid %b want 0 0", b_count[2:0], b_pop_valid[0]); else n_pass++;
    endtask

    task automatic test_flush_and_reset();
        for (int k = 0; k < 2; k++) begin
            push_valid = 16'h0081;
            pdata[0] = 8'($urandom);
            pdata[7] = 8'($urandom);
            #1; predict(); commit();
        end
        push_valid = 16'h0081;
        pop_ready = 16'h0081;
        flush = 1'b1;
        #1;
        predict();
        n_total++; if (wen !== 16'h0000) $display("FAIL flush_wen got %h want 0", wen); else n_pass++;
        n_total++; if (rd_addr !== '0) $display("FAIL flush_rd_addr got %h want 0", rd_addr); else n_pass++;
        commit();
        flush = 1'b0;
        push_valid = '0;
        pop_ready = '0;
        #1;
        n_total++; if (count[2:0] !== 3'd0 || count[23:21] !== 3'd0) $display("FAIL flush_count got %0d/%0d want 0/0", count[2:0], count[23:21]); else n_pass++;
        n_total++; if (pop_valid !== 16'h0000) $display("FAIL flush_pop_valid got %h want 0", pop_valid); else n_pass++;
        // refill several lanes, then reset asynchronously away from any edge
        for (int k = 0; k < 3; k++) begin
            push_valid = 16'h5A5A;
            #1; predict(); commit();
        end
        push_valid = 16'hFFFF;
        pop_ready = 16'hFFFF;
        #2;
        rst = 1'b1;
        #1;
        n_total++; if (push_ready !== 16'hFFFF) $display("FAIL rst_push_ready got %h want ffff", push_ready); else n_pass++;
        n_total++; if (pop_valid !== 16'h0000) $display("FAIL rst_pop_valid got %h want 0", pop_valid); else n_pass++;
        n_total++; if (wen !== 16'h0000) $display("FAIL rst_wen got %h want 0", wen); else n_pass++;
        n_total++; if (count !== '0 || wr_addr !== '0 || rd_addr !== '0) $display("FAIL rst_state got %h/%h/%h want 0", count, wr_addr, rd_addr); else n_pass++;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            push_valid = 16'($urandom);
            pop_ready  = 16'($urandom);
            flush      = ($urandom_range(0, 50) == 0);
            for (int l = 0; l < TN; l++) pdata[l] = 8'($urandom);
            #1;
            predict();
            for (int l = 0; l < TN; l++) begin
                n_total++;
                if (push_ready[l] !== e_ready[l] || pop_valid[l] !== e_valid[l] || wen[l] !== e_wen[l])
                    $display("FAIL rand_flags c=%0d lane=%0d got r%b v%b w%b want r%b v%b w%b", c, l,
                             push_ready[l], pop_valid[l], wen[l], e_ready[l], e_valid[l], e_wen[l]);
                else n_pass++;
                n_total++;
                if (wr_addr[l*AW +: AW] !== AW'(e_wr[l]) || rd_addr[l*AW +: AW] !== AW'(e_rd[l]) || count[l*CW +: CW] !== CW'(e_cnt[l]))
                    $display("FAIL rand_state c=%0d lane=%0d got wr%0d rd%0d n%0d want wr%0d rd%0d n%0d", c, l,
                             wr_addr[l*AW +: AW], rd_addr[l*AW +: AW], count[l*CW +: CW], e_wr[l], e_rd[l], e_cnt[l]);
                else n_pass++;
                if (e_valid[l]) begin
                    n_total++;
                    if (head(l) !== q[l][0]) $display("FAIL rand_data c=%0d lane=%0d got %h want %h", c, l, head(l), q[l][0]);
                    else n_pass++;
                end
            end
            commit();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_fill_lane3();
        test_drain_lane3();
        test_stream_lane0();
        test_nw3();
        test_flush_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
